// File: rtl/cr_command_ctrl_if.sv
// Bus/channel-side signals of the 68681 DUART command-register controller.
// The master modport is the CPU-decode/channel side; the slave modport is the controller.
interface cr_command_ctrl_if;
  logic       cs;
  logic       rw;
  logic [7:0] data;
  logic       tx_empty;
  logic       baud_tick;
  logic       mr_ptr_rst;
  logic       rx_rst;
  logic       tx_rst;
  logic       err_rst;
  logic       brk_int_rst;
  logic       rx_en;
  logic       tx_en;
  logic       tx_break;

  modport master (
    output cs, rw, data, tx_empty, baud_tick,
    input  mr_ptr_rst, rx_rst, tx_rst, err_rst, brk_int_rst, rx_en, tx_en, tx_break
  );

  modport slave (
    input  cs, rw, data, tx_empty, baud_tick,
    output mr_ptr_rst, rx_rst, tx_rst, err_rst, brk_int_rst, rx_en, tx_en, tx_break
  );
endinterface

// File: rtl/cr_command_ctrl.sv
// Per-channel command-register controller for the 68681 DUART: decodes CR writes into
// reset pulses, Rx/Tx enable levels (with deferred Tx disable) and a minimum-length break FSM.
module cr_command_ctrl #(
  parameter int BREAK_MIN_TICKS = 16,
  parameter int CNT_W           = 8
) (
  input logic               clk,
  input logic               MrReset,
  cr_command_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT_EMPTY, ACTIVE, STOPPING} brkState_e;

  localparam logic [CNT_W-1:0] BRK_MIN = CNT_W'(BREAK_MIN_TICKS);

  brkState_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrPrev_q;
  logic             rxEn_q, rxEn_d;
  logic             txEn_q, txEn_d;
  logic             txDisPend_q, txDisPend_d;
  logic             txBreak_q, txBreak_d;
  logic             mrPtrRst_q, mrPtrRst_d;
  logic             rxRst_q, rxRst_d;
  logic             txRst_q, txRst_d;
  logic             errRst_q, errRst_d;
  logic             brkIntRst_q, brkIntRst_d;

  logic       wr;
  logic       capture;
  logic [2:0] miscCmd;
  logic [1:0] txCmd;
  logic [1:0] rxCmd;

  assign wr      = bus.cs & ~bus.rw;
  assign capture = wr & ~wrPrev_q;
  assign miscCmd = bus.data[6:4];
  assign txCmd   = bus.data[3:2];
  assign rxCmd   = bus.data[1:0];

  // Free-running break timing first, then the captured command (misc field before Tx/Rx fields).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rxEn_d      = rxEn_q;
    txEn_d      = txEn_q;
    txDisPend_d = txDisPend_q;
    mrPtrRst_d  = 1'b0;
    rxRst_d     = 1'b0;
    txRst_d     = 1'b0;
    errRst_d    = 1'b0;
    brkIntRst_d = 1'b0;

    if ((state_q == ACTIVE || state_q == STOPPING) && bus.baud_tick && cnt_q < BRK_MIN)
      cnt_d = cnt_q + 1'b1;

    case (state_q)
      WAIT_EMPTY: if (bus.tx_empty) begin
        state_d = ACTIVE;
        cnt_d   = '0;
      end
      STOPPING: if (cnt_d >= BRK_MIN) state_d = IDLE;
      default: ;
    endcase

    if (capture) begin
      case (miscCmd)
        3'b001: mrPtrRst_d = 1'b1;
        3'b010: begin
          rxRst_d = 1'b1;
          rxEn_d  = 1'b0;
        end
        3'b011: begin
          txRst_d     = 1'b1;
          txEn_d      = 1'b0;
          txDisPend_d = 1'b0;
          state_d     = IDLE;
          cnt_d       = '0;
        end
        3'b100: errRst_d    = 1'b1;
        3'b101: brkIntRst_d = 1'b1;
        3'b111: begin
          if (state_q == WAIT_EMPTY)
            state_d = IDLE;
          else if (state_q == ACTIVE)
            state_d = (cnt_d >= BRK_MIN) ? IDLE : STOPPING;
        end
        default: ;
      endcase

      case (txCmd)
        2'b01: begin
          txEn_d      = 1'b1;
          txDisPend_d = 1'b0;
        end
        2'b10: begin
          if (bus.tx_empty && state_d == IDLE) txEn_d = 1'b0;
          else txDisPend_d = 1'b1;
        end
        default: ;
      endcase

      case (rxCmd)
        2'b01:   rxEn_d = 1'b1;
        2'b10:   rxEn_d = 1'b0;
        default: ;
      endcase

      // Start break looks at tx_en after this write's Tx field has been applied.
      if (miscCmd == 3'b110 && state_q == IDLE && txEn_d)
        state_d = WAIT_EMPTY;
    end

    if (txDisPend_d && bus.tx_empty && state_d == IDLE) begin
      txEn_d      = 1'b0;
      txDisPend_d = 1'b0;
    end

    txBreak_d = (state_d == ACTIVE) || (state_d == STOPPING);
  end

  always_ff @(posedge clk) begin
    if (MrReset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wrPrev_q    <= 1'b0;
      rxEn_q      <= 1'b0;
      txEn_q      <= 1'b0;
      txDisPend_q <= 1'b0;
      txBreak_q   <= 1'b0;
      mrPtrRst_q  <= 1'b0;
      rxRst_q     <= 1'b0;
      txRst_q     <= 1'b0;
      errRst_q    <= 1'b0;
      brkIntRst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wrPrev_q    <= wr;
      rxEn_q      <= rxEn_d;
      txEn_q      <= txEn_d;
      txDisPend_q <= txDisPend_d;
      txBreak_q   <= txBreak_d;
      mrPtrRst_q  <= mrPtrRst_d;
      rxRst_q     <= rxRst_d;
      txRst_q     <= txRst_d;
      errRst_q    <= errRst_d;
      brkIntRst_q <= brkIntRst_d;
    end
  end

  assign bus.mr_ptr_rst  = mrPtrRst_q;
  assign bus.rx_rst      = rxRst_q;
  assign bus.tx_rst      = txRst_q;
  assign bus.err_rst     = errRst_q;
  assign bus.brk_int_rst = brkIntRst_q;
  assign bus.rx_en       = rxEn_q;
  assign bus.tx_en       = txEn_q;
  assign bus.tx_break    = txBreak_q;

endmodule

// File: tb/tb_cr_command_ctrl.sv
// Scoreboard bench for cr_command_ctrl: directed CR writes push hand-computed output
// vectors {mr,rxr,txr,err,brk,rx_en,tx_en,tx_break}; a negedge monitor pops and compares.
module tb_cr_command_ctrl;

  localparam logic [7:0] MR   = 8'h80;
  localparam logic [7:0] RXR  = 8'h40;
  localparam logic [7:0] TXR  = 8'h20;
  localparam logic [7:0] ERR  = 8'h10;
  localparam logic [7:0] BRK  = 8'h08;
  localparam logic [7:0] RXEN = 8'h04;
  localparam logic [7:0] TXEN = 8'h02;
  localparam logic [7:0] TXB  = 8'h01;

  typedef struct {
    int         cyc;
    logic [7:0] outs;
    string      name;
  } exp_t;

  logic clk;
  logic MrReset;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sbQ[$];

  cr_command_ctrl_if bus();

  cr_command_ctrl #(.BREAK_MIN_TICKS(16), .CNT_W(8)) dut (
    .clk     (clk),
    .MrReset (MrReset),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs just after an edge; the outputs after the next edge must equal expOut.
  task automatic applyStimulus(input logic rst, input logic cs, input logic rw,
                               input logic [7:0] d, input logic txe, input logic tick,
                               input logic [7:0] expOut, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    MrReset       = rst;
    bus.cs        = cs;
    bus.rw        = rw;
    bus.data      = d;
    bus.tx_empty  = txe;
    bus.baud_tick = tick;
    e.cyc  = cyc + 1;
    e.outs = expOut;
    e.name = name;
    sbQ.push_back(e);
  endtask

  task automatic writeCr(input logic [7:0] d, input logic txe,
                         input logic [7:0] expOut, input string name);
    applyStimulus(1'b0, 1'b1, 1'b0, d, txe, 1'b0, expOut, name);
  endtask

  task automatic idle(input logic txe, input logic tick,
                      input logic [7:0] expOut, input string name);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, txe, tick, expOut, name);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [7:0] act;
    act = {bus.mr_ptr_rst, bus.rx_rst, bus.tx_rst, bus.err_rst, bus.brk_int_rst,
           bus.rx_en, bus.tx_en, bus.tx_break};
    checks++;
    if (e.cyc != cyc || act !== e.outs) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d/%0d actual=%b required=%b", e.name, cyc, e.cyc, act, e.outs);
    end
  endtask

  always @(negedge clk) begin
    while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) checkOutput(sbQ.pop_front());
  end

  initial begin
    cyc           = 0;
    checks        = 0;
    failures      = 0;
    MrReset       = 1'b1;
    bus.cs        = 1'b0;
    bus.rw        = 1'b0;
    bus.data      = 8'h00;
    bus.tx_empty  = 1'b0;
    bus.baud_tick = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, "reset0");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h35, 1'b1, 1'b0, 8'h00, "reset1");
    idle(1'b1, 1'b0, 8'h00, "postReset");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h15, 1'b1, 1'b0, 8'h00, "readIgnored");
    idle(1'b1, 1'b0, 8'h00, "readIgnored2");

    writeCr(8'h05, 1'b1, RXEN | TXEN, "enable05");
    idle(1'b1, 1'b0, RXEN | TXEN, "enable05Hold");

    writeCr(8'h10, 1'b1, MR | RXEN | TXEN, "mrPtrPulse");
    for (int i = 0; i < 4; i++) writeCr(8'h10, 1'b1, RXEN | TXEN, "mrPtrHeld");
    idle(1'b1, 1'b0, RXEN | TXEN, "mrPtrDone");
    writeCr(8'h90, 1'b1, MR | RXEN | TXEN, "bit7Ignored");
    idle(1'b1, 1'b0, RXEN | TXEN, "bit7Done");

    writeCr(8'h40, 1'b1, ERR | RXEN | TXEN, "errRst");
    idle(1'b1, 1'b0, RXEN | TXEN, "errRstDone");
    writeCr(8'h50, 1'b1, BRK | RXEN | TXEN, "brkIntRst");
    idle(1'b1, 1'b0, RXEN | TXEN, "brkIntRstDone");

    writeCr(8'h08, 1'b0, RXEN | TXEN, "txDisDeferred");
    idle(1'b0, 1'b0, RXEN | TXEN, "txDisWaiting");
    idle(1'b1, 1'b0, RXEN, "txDisResolved");

    writeCr(8'h04, 1'b1, RXEN | TXEN, "txReEnable");
    idle(1'b0, 1'b0, RXEN | TXEN, "txReEnableDone");
    writeCr(8'h08, 1'b0, RXEN | TXEN, "txDisPend2");
    idle(1'b0, 1'b0, RXEN | TXEN, "txDisPend2Gap");
    writeCr(8'h04, 1'b0, RXEN | TXEN, "txPendCancel");
    idle(1'b1, 1'b0, RXEN | TXEN, "txPendCancelled");

    writeCr(8'h08, 1'b1, RXEN, "txDisImmediate");
    idle(1'b1, 1'b0, RXEN, "txDisImmGap");
    writeCr(8'h04, 1'b1, RXEN | TXEN, "txEnAgain");
    idle(1'b1, 1'b0, RXEN | TXEN, "txEnAgainGap");

    writeCr(8'h70, 1'b1, RXEN | TXEN, "stopWhileIdle");
    idle(1'b1, 1'b0, RXEN | TXEN, "stopIdleGap");

    writeCr(8'h60, 1'b1, RXEN | TXEN, "startBreak");
    idle(1'b1, 1'b0, RXEN | TXEN | TXB, "breakActive");
    for (int i = 0; i < 3; i++) begin
      idle(1'b1, 1'b1, RXEN | TXEN | TXB, "breakTick");
      idle(1'b1, 1'b0, RXEN | TXEN | TXB, "breakNoTick");
    end
    writeCr(8'h70, 1'b1, RXEN | TXEN | TXB, "stopEarly");
    idle(1'b1, 1'b0, RXEN | TXEN | TXB, "stopping");
    writeCr(8'h40, 1'b1, ERR | RXEN | TXEN | TXB, "errDuringBreak");
    idle(1'b1, 1'b0, RXEN | TXEN | TXB, "stoppingGap");
    for (int i = 0; i < 12; i++) idle(1'b1, 1'b1, RXEN | TXEN | TXB, "stoppingTick");
    idle(1'b1, 1'b1, RXEN | TXEN, "breakMinReached");
    idle(1'b1, 1'b0, RXEN | TXEN, "breakEnded");

    writeCr(8'h60, 1'b1, RXEN | TXEN, "startBreak2");
    idle(1'b1, 1'b0, RXEN | TXEN | TXB, "break2Active");
    for (int i = 0; i < 17; i++) idle(1'b1, 1'b1, RXEN | TXEN | TXB, "break2Tick");
    writeCr(8'h70, 1'b1, RXEN | TXEN, "stopLate");
    idle(1'b1, 1'b0, RXEN | TXEN, "stopLateGap");

    writeCr(8'h60, 1'b1, RXEN | TXEN, "startBreak3");
    idle(1'b1, 1'b0, RXEN | TXEN | TXB, "break3Active");
    writeCr(8'h30, 1'b1, TXR | RXEN, "txRstAbort");
    idle(1'b1, 1'b0, RXEN, "txRstDone");

    writeCr(8'h60, 1'b1, RXEN, "startTxOff");
    idle(1'b1, 1'b0, RXEN, "startTxOffGap");
    idle(1'b1, 1'b0, RXEN, "startTxOffGap2");

    writeCr(8'h64, 1'b1, RXEN | TXEN, "enableAndStart");
    idle(1'b1, 1'b0, RXEN | TXEN | TXB, "enableAndStartActive");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, "resetMidBreak");
    idle(1'b1, 1'b0, 8'h00, "afterReset");

    writeCr(8'h25, 1'b1, RXR | RXEN | TXEN, "rxRstPlusEnable");
    idle(1'b1, 1'b0, RXEN | TXEN, "rxRstDone");
    writeCr(8'h20, 1'b1, RXR | TXEN, "rxRstClears");
    idle(1'b1, 1'b0, TXEN, "rxRstClearsDone");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, "finalReset");

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    if (sbQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboardDrain actual=%0d pending required=0", sbQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
